rr_grant_encoder_32: RTL and testbench

Sequential round-robin arbiter for 32 requesters that produces a registered 5-bit grant index plus valid. It sits directly upstream of the 5:32 decoder: `Grant_Valid_Out` drives the decoder's `Enable_In`, and `Grant_Index_Out` drives `Encoded_Value_In`. The decoder's one-hot output therefore selects exactly one granted requester. Grants are held with a valid/ready handshake and rotate fairly.

---
 rtl/rr_grant_encoder_32_pkg.sv | 13 +
 rtl/rr_grant_encoder_32_pick.sv | 30 +++
 rtl/rr_grant_encoder_32.sv | 95 +++++++++
 tb/tb_rr_grant_encoder_32.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_encoder_32_pkg.sv
// Shared constants and state type for the 32-way round-robin grant encoder.
package rr_arb_pkg;

    localparam int NUM_REQ = 32;
    localparam int IDX_W   = 5;
    localparam int CNT_W   = 16;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_grant_encoder_32_pick.sv
// Combinational round-robin pick: rotate requests so Pointer lands at bit 0,
// find the lowest set bit, then add Pointer back to get the absolute index.
module rr_priority_pick
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   pick_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     enc;

    always_comb begin
        dbl = {req_i, req_i};
        rot = NUM_REQ'(dbl >> ptr_i);
        enc = '0;
        // Scan high to low so the lowest set bit wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = IDX_W'(i);
            end
        end
        pick_o = enc + ptr_i;
        any_o  = |req_i;
    end

endmodule

// File: rtl/rr_grant_encoder_32.sv
// Round-robin arbiter for 32 requesters with a registered grant index/valid,
// valid/ready hold semantics and a saturating accepted-grant counter.
module rr_grant_encoder_32
    import rr_arb_pkg::*;
(
    input  logic               Clk_In,
    input  logic               Reset_n_In,
    input  logic               Enable_In,
    input  logic [NUM_REQ-1:0] Request_In,
    input  logic               Grant_Ready_In,
    output logic               Grant_Valid_Out,
    output logic [IDX_W-1:0]   Grant_Index_Out,
    output logic [CNT_W-1:0]   Grant_Count_Out,
    output arb_state_t         State_Dbg_Out
);

    // Handshake: a grant is offered while Grant_Valid_Out=1 and is consumed on
    // any cycle where Grant_Ready_In=1; until then index/valid stay frozen.
    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic [IDX_W-1:0]   pick_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    assign accept   = (state_q == GRANTED) && Grant_Ready_In;
    // On accept the follow-on grant must already see the rotated pointer.
    assign pick_ptr = accept ? (idx_q + IDX_W'(1)) : ptr_q;

    rr_priority_pick u_pick (
        .req_i  (Request_In),
        .ptr_i  (pick_ptr),
        .pick_o (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Enable_In && pick_any) begin
                    idx_d   = pick_idx;
                    valid_d = 1'b1;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                if (Grant_Ready_In) begin
                    ptr_d = idx_q + IDX_W'(1);
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    if (Enable_In && pick_any) begin
                        idx_d = pick_idx;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Grant_Valid_Out = valid_q;
    assign Grant_Index_Out = idx_q;
    assign Grant_Count_Out = cnt_q;
    assign State_Dbg_Out   = state_q;

endmodule

// File: tb/tb_rr_grant_encoder_32.sv
// Directed bench for rr_grant_encoder_32 with a reference model feeding an
// expected-output queue that is checked one cycle after each driven step.
module tb_rr_grant_encoder_32;
  import rr_arb_pkg::*;

  localparam int EXP_W = 1 + 1 + IDX_W + CNT_W;

  // clock / reset
  logic               clk;
  logic               rst_n;
  logic               en;
  logic [NUM_REQ-1:0] req;
  logic               rdy;
  logic               valid_o;
  logic [IDX_W-1:0]   idx_o;
  logic [CNT_W-1:0]   cnt_o;
  arb_state_t         state_o;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  rr_grant_encoder_32 dut (
    .Clk_In          (clk),
    .Reset_n_In      (rst_n),
    .Enable_In       (en),
    .Request_In      (req),
    .Grant_Ready_In  (rdy),
    .Grant_Valid_Out (valid_o),
    .Grant_Index_Out (idx_o),
    .Grant_Count_Out (cnt_o),
    .State_Dbg_Out   (state_o)
  );

  // reference model
  logic             m_valid;
  logic [IDX_W-1:0] m_idx;
  logic [IDX_W-1:0] m_ptr;
  logic [CNT_W-1:0] m_cnt;

  logic [EXP_W-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  function automatic logic [IDX_W-1:0] model_pick(input logic [NUM_REQ-1:0] r,
                                                  input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] k;
    model_pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = p + IDX_W'(i);
      if (r[k]) model_pick = k;
    end
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = '0;
    m_ptr   = '0;
    m_cnt   = '0;
  endtask

  task automatic model_step(input logic e, input logic [NUM_REQ-1:0] r, input logic g);
    if (!m_valid) begin
      if (e && (r != '0)) begin
        m_idx   = model_pick(r, m_ptr);
        m_valid = 1'b1;
      end
    end else if (g) begin
      m_ptr = m_idx + 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
      if (e && (r != '0)) m_idx = model_pick(r, m_ptr);
      else m_valid = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one clock with the given inputs; scoreboard pops after the edge
  task automatic drive(input logic e, input logic [NUM_REQ-1:0] r, input logic g);
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] obs_v;
    en  = e;
    req = r;
    rdy = g;
    model_step(e, r, g);
    exp_q.push_back({m_valid, m_valid, m_idx, m_cnt});
    @(posedge clk);
    #1;
    obs_v = {logic'(state_o), valid_o, idx_o, cnt_o};
    exp_v = exp_q.pop_front();
    n_cmp++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL step: observed state/valid/idx/cnt=%0b/%0b/%0d/%h expected=%0b/%0b/%0d/%h",
             obs_v[EXP_W-1], obs_v[EXP_W-2], obs_v[CNT_W+IDX_W-1:CNT_W], obs_v[CNT_W-1:0],
             exp_v[EXP_W-1], exp_v[EXP_W-2], exp_v[CNT_W+IDX_W-1:CNT_W], exp_v[CNT_W-1:0]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    en    = 1'b0;
    req   = '0;
    rdy   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_index", 32'(idx_o), 32'd0);
    check("reset_count", 32'(cnt_o), 32'd0);
    check("reset_state", 32'(state_o), 32'(IDLE));
    rst_n = 1'b1;

    // single requester 0, held with ready low
    drive(1'b1, 32'h0000_0001, 1'b0);
    check("first_grant_idx", 32'(idx_o), 32'd0);
    check("first_grant_valid", 32'(valid_o), 32'd1);
    repeat (5) drive(1'b1, 32'h0000_0001, 1'b0);
    check("hold_count", 32'(cnt_o), 32'd0);

    // all requesting, ready high: full rotation back-to-back
    repeat (33) drive(1'b1, 32'hFFFF_FFFF, 1'b1);
    check("rotation_count", 32'(cnt_o), 32'd33);
    check("rotation_idx", 32'(idx_o), 32'd1);

    // wrap fairness between 31 and 0
    repeat (4) drive(1'b1, 32'h8000_0001, 1'b1);
    // single requester re-granted
    repeat (3) drive(1'b1, 32'h0000_0100, 1'b1);
    check("single_regrant", 32'(idx_o), 32'd8);

    // drain to idle, ready ignored in IDLE
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'hFFFF_FFFF, 1'b1);
    check("idle_state", 32'(state_o), 32'(IDLE));

    // grant 5 held after request/enable drop, then accepted without follow-on
    drive(1'b1, 32'h0000_0020, 1'b0);
    check("grant5_idx", 32'(idx_o), 32'd5);
    repeat (3) drive(1'b0, 32'h0, 1'b0);
    check("grant5_held", 32'(idx_o), 32'd5);
    drive(1'b0, 32'h0, 1'b1);
    check("grant5_drop", 32'(valid_o), 32'd0);

    // accept coinciding with enable fall while requests pending
    drive(1'b1, 32'h0000_0300, 1'b0);
    drive(1'b0, 32'h0000_0300, 1'b1);
    check("accept_en_fall", 32'(valid_o), 32'd0);

    // reset mid-grant
    drive(1'b1, 32'h0000_1000, 1'b0);
    check("grant12_idx", 32'(idx_o), 32'd12);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_index", 32'(idx_o), 32'd0);
    check("midrst_count", 32'(cnt_o), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'h0000_1000, 1'b0);
    check("post_rst_idx", 32'(idx_o), 32'd12);

    // saturation of the accepted-grant counter
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, 32'(($urandom_range(0, 1) << 31) | $urandom_range(1, 65535)), 1'b1);
    end
    check("count_saturated", 32'(cnt_o), 32'h0000_FFFF);
    repeat (3) drive(1'b1, 32'hFFFF_FFFF, 1'b1);
    check("count_stays", 32'(cnt_o), 32'h0000_FFFF);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
